// File: rtl/basic_toggle_deserializer.sv
// basic_toggle_deserializer
// Recovers one bit per WINDOW-cycle slot from a toggle-encoded input,
// assembles WIDTH slots LSB-first into a word and queues completed words
// in a DEPTH-entry FIFO with a valid/ready read port. Sticky flags report
// slots that saw more than one toggle and words lost to a full FIFO.
module basic_toggle_deserializer #(
    parameter int WIDTH  = 8,
    parameter int WINDOW = 4,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     din,
    input  logic                     clear,
    output logic [WIDTH-1:0]         word,
    output logic                     word_valid,
    input  logic                     word_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic                     collision
);

    localparam int CW = $clog2(WINDOW);
    localparam int BW = $clog2(WIDTH);
    localparam int AW = $clog2(DEPTH);

    localparam logic [CW-1:0] SLOT_LAST = CW'(WINDOW - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);
    localparam logic [AW:0]   FIFO_FULL = (AW+1)'(DEPTH);

    // Synchronizer and edge reference
    logic s1_q, s2_q, s3_q;
    logic pulse;

    // Slot framing and word assembly
    logic [CW-1:0]    slot_cnt_q, slot_cnt_d;
    logic [BW-1:0]    bit_cnt_q,  bit_cnt_d;
    logic             hit_q,      hit_d;
    logic [WIDTH-1:0] shreg_q,    shreg_d;

    logic             slot_end;
    logic             slot_bit;
    logic             word_done;
    logic [WIDTH-1:0] full_word;

    // FIFO
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             fifo_full;
    logic             pop;
    logic             push_ok;

    // Flags
    logic overflow_q,  overflow_d;
    logic collision_q, collision_d;
    logic ovf_set;
    logic coll_set;

    // s3 always follows s2, so holding en low absorbs any idle-level change
    // instead of reporting it as a toggle once capture starts.
    assign pulse     = en & (s2_q ^ s3_q);
    assign slot_end  = en & (slot_cnt_q == SLOT_LAST);
    assign slot_bit  = hit_q | pulse;
    assign word_done = slot_end & (bit_cnt_q == BIT_LAST);
    assign full_word = shreg_q | ({{(WIDTH-1){1'b0}}, slot_bit} << bit_cnt_q);

    assign level      = wr_ptr_q - rd_ptr_q;
    assign fifo_full  = (level == FIFO_FULL);
    assign word_valid = (level != '0);
    assign word       = word_valid ? mem_q[rd_ptr_q[AW-1:0]] : '0;
    assign pop        = word_valid & word_ready;
    // A pop on the same edge frees the slot, so a push into a full FIFO is kept.
    assign push_ok    = word_done & (~fifo_full | pop);
    assign ovf_set    = word_done & fifo_full & ~pop;
    assign coll_set   = pulse & hit_q;

    assign overflow  = overflow_q;
    assign collision = collision_q;

    // Next-state for slot counter, bit counter, hit flag and shift register
    always_comb begin
        slot_cnt_d = slot_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        hit_d      = hit_q;
        shreg_d    = shreg_q;
        if (!en) begin
            slot_cnt_d = '0;
            bit_cnt_d  = '0;
            hit_d      = 1'b0;
            shreg_d    = '0;
        end else if (slot_end) begin
            slot_cnt_d = '0;
            hit_d      = 1'b0;
            if (word_done) begin
                bit_cnt_d = '0;
                shreg_d   = '0;
            end else begin
                bit_cnt_d = bit_cnt_q + 1'b1;
                shreg_d   = full_word;
            end
        end else begin
            slot_cnt_d = slot_cnt_q + 1'b1;
            hit_d      = hit_q | pulse;
        end
    end

    // Next-state for FIFO pointers and sticky flags; a set beats clear
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        overflow_d  = overflow_q;
        collision_d = collision_q;
        if (pop)
            rd_ptr_d = rd_ptr_q + 1'b1;
        if (push_ok)
            wr_ptr_d = wr_ptr_q + 1'b1;
        if (clear) begin
            overflow_d  = 1'b0;
            collision_d = 1'b0;
        end
        if (ovf_set)
            overflow_d = 1'b1;
        if (coll_set)
            collision_d = 1'b1;
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q        <= 1'b0;
            s2_q        <= 1'b0;
            s3_q        <= 1'b0;
            slot_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            hit_q       <= 1'b0;
            shreg_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            collision_q <= 1'b0;
        end else begin
            s1_q        <= din;
            s2_q        <= s1_q;
            s3_q        <= s2_q;
            slot_cnt_q  <= slot_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            hit_q       <= hit_d;
            shreg_q     <= shreg_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overflow_q  <= overflow_d;
            collision_q <= collision_d;
        end
    end

    // FIFO storage; contents are only visible through valid pointers
    always_ff @(posedge clk) begin
        if (push_ok)
            mem_q[wr_ptr_q[AW-1:0]] <= full_word;
    end

endmodule

// File: doc/basic_toggle_deserializer.md
# basic_toggle_deserializer

Clocked capture stage placed directly downstream of the basic XOR cell model. It consumes the cell's toggle-encoded `out` signal, where each output event is a level flip. It recovers one bit per fixed-length time slot and assembles `WIDTH` slots into a word. Completed words are buffered in a small FIFO with a valid/ready handshake, and sticky flags report merged events and dropped words.

## Interface
- `WIDTH`, 8: bits per assembled word (≥2).
- `WINDOW`, 4: clock cycles per bit slot (≥2).
- `DEPTH`, 4: FIFO entries (power of two, ≥2).

- `clk`  in  1  sampling clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  capture enable; low holds and clears slot framing.
- `din`  in  1  toggle-encoded input from the XOR cell `out`; asynchronous to `clk`.
- `clear`  in  1  synchronous clear of sticky flags.
- `word`  out  WIDTH  FIFO head word; 0 when empty.
- `word_valid`  out  1  FIFO non-empty.
- `word_ready`  in  1  consumer accepts `word` this cycle.
- `level`  out  clog2(DEPTH)+1  FIFO occupancy.
- `overflow`  out  1  sticky; a completed word was dropped.
- `collision`  out  1  sticky; more than one toggle occurred in a single slot.

## Operation
- **Synchronizer.**
  - `din` passes through two flops (`s1`, `s2`) and a reference flop `s3`.
  - `pulse = s2 ^ s3`.
  - While `en` = 0, `s3` loads `s2` and `pulse` is forced to 0. The idle level of `din` is therefore never counted.
- **Slot counter.**
  - Runs 0..`WINDOW`-1, incrementing every cycle while `en` = 1, and wraps to 0.
  - `hit` flop: set by `pulse`, cleared at slot end.
  - A `pulse` while `hit` = 1, or while `hit` is being set at slot end, sets `collision`. The slot bit stays 1.
- **Slot end** (counter = `WINDOW`-1):
  - `bit = hit | pulse`.
  - The bit is written into the shift register at the position given by the bit counter (0..`WIDTH`-1). The first slot goes to bit 0 (LSB first).
- **Word completion.**
  - On the slot-end edge with bit counter = `WIDTH`-1, the full word, including the final bit, is pushed to the FIFO.
  - The bit counter and shift register then return to 0.
- **FIFO.**
  - Pop occurs on an edge where `word_valid` & `word_ready`.
  - Push when full is dropped and sets `overflow`.
  - Push and pop on the same edge while full: the pop is applied first and the push is accepted, so `level` is unchanged.
  - Push and pop on the same edge while empty is impossible, because `word_valid` = 0.
- **Enable low.**
  - Any edge with `en` = 0 clears the slot counter, bit counter, `hit` and shift register, discarding any partial word.
  - FIFO contents, flags and the handshake are unaffected.
- **Clear.**
  - `clear` = 1 zeroes `overflow` and `collision`.
  - If a set condition occurs on the same edge, the set wins.
- **Reset.**
  - `rst_n` low immediately zeroes every flop: synchronizer, counters, `hit`, shift register, FIFO pointers, and both flags.
  - Outputs: `word` = 0, `word_valid` = 0, `level` = 0, `overflow` = 0, `collision` = 0.
  - Asserting reset mid-word or with a non-empty FIFO discards everything.

## Timing
- A `din` edge appears as `pulse` 2–3 `clk` edges later, depending on the synchronizer. The slot boundaries are relative to the synchronized `pulse`.
- The first slot starts on the first edge with `en` = 1. Slot k ends on the edge at cycle k·`WINDOW`+`WINDOW`-1 after enable.
- `word_valid` and `level` update on the push edge, with zero additional latency.
- `word` is combinationally the head entry and updates on the pop edge.
- The word period is `WIDTH`·`WINDOW` cycles. The consumer sustains full rate if it pops at least once per word period.
- `din` toggles spaced fewer than `WINDOW` cycles apart can merge into one slot. Upstream must honour this spacing; violations are reported by `collision`.

## Test plan
- **Reset:** `rst_n` = 0 mid-operation with 2 words queued → `word` = 0, `word_valid` = 0, `level` = 0, `overflow` = 0, `collision` = 0 immediately. After release, no word appears without `din` toggles.
- **Basic capture** (`WIDTH` = 8, `WINDOW` = 4, `en` = 1, `word_ready` = 1): single `din` toggle in slots 0, 2 and 7 → one word 8'h85, `word_valid` for one cycle, `collision` = 0.
- **Collision:** two `din` toggles 1 cycle apart inside slot 3, no other toggles → word 8'h08, `collision` = 1. Pulse `clear` → `collision` = 0.
- **Overflow** (`DEPTH` = 4): `word_ready` = 0, five words 8'h01..8'h05 → `level` = 4, `overflow` = 1. Drain with `word_ready` = 1 → 01, 02, 03, 04 in order, then `level` = 0. Full-plus-simultaneous-pop case → push accepted, `overflow` unchanged.
- **Enable drop:** `en` low after 3 slots containing toggles, then high and 8 idle slots → no partial word; the next word is 8'h00, aligned to the `en` rise.
- **Idle level:** `din` held at 1 before `en` rises → no spurious `pulse`; the first word is 8'h00.
